// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART bus controller and its bench.
//   - register offsets (addr[3:2] of the CPU access)
//   - STATUS / CTRL bit positions
//   - scheduler state encoding
//   - reset baud divisor and the smallest divisor accepted from software
package uart_pkg;

  // Register word offsets, compared against addr[3:2].
  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_STAT = 2'd1;
  localparam logic [1:0] UART_BAUD = 2'd2;
  localparam logic [1:0] UART_CTRL = 2'd3;

  // STATUS bit positions.
  localparam int STAT_TX_BUSY   = 0;
  localparam int STAT_TXQ_FULL  = 1;
  localparam int STAT_TXQ_EMPTY = 2;
  localparam int STAT_RX_EMPTY  = 3;
  localparam int STAT_TX_OVF    = 4;
  localparam int STAT_BAUD_PEND = 5;

  // CTRL bit positions.
  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_FLUSH = 1;

  // 50 MHz / 115200 baud.
  localparam logic [15:0] DEFAULT_CPB = 16'd434;
  localparam logic [15:0] MIN_CPB     = 16'd4;

  // The peripheral reports an empty RX FIFO with an all-ones word.
  localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;

  // Transmit scheduler states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACTIVE = 2'd2
  } sched_state_t;

  function automatic logic rx_is_empty(input logic [31:0] word);
    return word == RX_EMPTY_WORD;
  endfunction

endpackage

// File: rtl/uart_txq.sv
// uart_txq: circular FIFO buffering CPU transmit bytes.
//   clk, reset    : clock, asynchronous active-low reset
//   push/push_data: enqueue request and byte
//   pop           : dequeue the head entry (ignored when empty)
//   flush         : drop all entries this cycle; a push in the same cycle is lost
//   head          : current head entry (valid while !empty)
//   full/empty    : occupancy flags
//   count         : number of stored entries
// A push while full is accepted only if a pop frees a slot in the same cycle;
// otherwise the byte is dropped and the parent flags the overflow.
module uart_txq
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Storage is a few entries deep, so the head is read combinationally; the
  // scheduler registers it into tx_data at launch time.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic do_pop;
  logic do_push;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == FULL_COUNT);
  assign count  = count_reg;
  assign head   = mem[rd_ptr_reg];

  assign do_pop  = pop & ~empty & ~flush;
  // A full queue still accepts a byte when the head leaves in the same cycle.
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Power-of-two depth: pointer increments wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: memory-mapped front end for uart_peripheral.
//   clk, reset     : clock, asynchronous active-low reset
//   sel/we/re      : CPU access select, store and load strobes
//   addr, wdata    : byte offset (addr[3:2] picks the register), store data
//   rdata          : load data, combinational
//   uart_rdata     : peripheral RX word (all ones = RX empty)
//   tx_busy        : peripheral transmitter busy
//   tx_start       : one-cycle launch pulse, tx_data valid with it
//   read_rx        : one-cycle RX pop, asserted with a DATA load
//   clk_per_bit    : active baud divisor driven to the peripheral
// Registers: DATA (0x0), STATUS (0x4), BAUD (0x8), CTRL (0xC).
module uart_bus_ctrl #(
  parameter int          TXQ_DEPTH   = 4,
  parameter logic [15:0] DEFAULT_CPB = uart_pkg::DEFAULT_CPB,
  parameter logic [15:0] MIN_CPB     = uart_pkg::MIN_CPB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] uart_rdata,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        read_rx,
  output logic [15:0] clk_per_bit
);

  import uart_pkg::*;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [1:0] reg_sel;
  logic       wr_data;
  logic       wr_stat;
  logic       wr_baud;
  logic       wr_ctrl;
  logic       rd_any;
  logic       flush;
  logic       baud_write;

  assign reg_sel = addr[3:2];
  assign wr_data = sel & we & (reg_sel == UART_DATA);
  assign wr_stat = sel & we & (reg_sel == UART_STAT);
  assign wr_baud = sel & we & (reg_sel == UART_BAUD);
  assign wr_ctrl = sel & we & (reg_sel == UART_CTRL);
  assign rd_any  = sel & re;

  // Only a load from DATA consumes an RX byte.
  assign read_rx = rd_any & (reg_sel == UART_DATA);

  assign flush      = wr_ctrl & wdata[CTRL_FLUSH];
  // Divisors below the minimum would stall the peripheral; drop them.
  assign baud_write = wr_baud & (wdata[15:0] >= MIN_CPB);

  // ---------------------------------------------------------------------------
  // TX queue
  // ---------------------------------------------------------------------------
  logic                         q_pop;
  logic                         q_full;
  logic                         q_empty;
  logic [7:0]                   q_head;
  logic [$clog2(TXQ_DEPTH):0]   q_count;

  uart_txq #(
    .DEPTH (TXQ_DEPTH),
    .WIDTH (8)
  ) u_txq (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_data),
    .push_data (wdata[7:0]),
    .pop       (q_pop),
    .flush     (flush),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // A push that finds the queue full and no slot freed this cycle is lost.
  logic ovf_event;
  assign ovf_event = wr_data & ~flush & q_full & ~q_pop;

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  logic        tx_en_reg;
  logic        tx_ovf_reg;
  logic [15:0] baud_shadow_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_en_reg       <= 1'b1;
      tx_ovf_reg      <= 1'b0;
      baud_shadow_reg <= DEFAULT_CPB;
    end else begin
      if (ovf_event) begin
        tx_ovf_reg <= 1'b1;
      end else if (wr_stat & wdata[STAT_TX_OVF]) begin
        tx_ovf_reg <= 1'b0;
      end
      if (baud_write) begin
        baud_shadow_reg <= wdata[15:0];
      end
      if (wr_ctrl) begin
        tx_en_reg <= wdata[CTRL_TX_EN];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit scheduler
  // ---------------------------------------------------------------------------
  sched_state_t state_reg;
  logic         tx_start_reg;
  logic [7:0]   tx_data_reg;
  logic [15:0]  clk_per_bit_reg;
  logic         baud_pending_reg;
  logic         launch_wait_reg;

  logic apply_baud;
  logic launch;

  // The divisor is swapped only while idle with the transmitter quiet, so a
  // frame never sees its bit period change. A pending swap takes priority
  // over the next launch.
  assign apply_baud = (state_reg == IDLE) & baud_pending_reg & ~tx_busy;
  assign launch     = (state_reg == IDLE) & ~apply_baud & tx_en_reg &
                      ~q_empty & ~tx_busy;
  assign q_pop      = launch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      tx_start_reg     <= 1'b0;
      tx_data_reg      <= '0;
      clk_per_bit_reg  <= DEFAULT_CPB;
      baud_pending_reg <= 1'b0;
      launch_wait_reg  <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (apply_baud) begin
            clk_per_bit_reg  <= baud_shadow_reg;
            baud_pending_reg <= 1'b0;
          end else if (launch) begin
            tx_data_reg     <= q_head;
            tx_start_reg    <= 1'b1;
            launch_wait_reg <= 1'b0;
            state_reg       <= LAUNCH;
          end
        end
        LAUNCH: begin
          // Give the peripheral two cycles to raise busy; move on regardless
          // so a missed handshake cannot wedge the scheduler.
          if (tx_busy || launch_wait_reg) begin
            state_reg <= ACTIVE;
          end else begin
            launch_wait_reg <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!tx_busy) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // A new shadow value written in the same cycle as an apply re-arms the
      // pending flag so the newer value is applied on the next idle cycle.
      if (baud_write) begin
        baud_pending_reg <= 1'b1;
      end
    end
  end

  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign clk_per_bit = clk_per_bit_reg;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (rd_any) begin
      case (reg_sel)
        UART_DATA: rdata = uart_rdata;
        UART_STAT: begin
          rdata[STAT_TX_BUSY]   = tx_busy;
          rdata[STAT_TXQ_FULL]  = q_full;
          rdata[STAT_TXQ_EMPTY] = q_empty;
          rdata[STAT_RX_EMPTY]  = rx_is_empty(uart_rdata);
          rdata[STAT_TX_OVF]    = tx_ovf_reg;
          rdata[STAT_BAUD_PEND] = baud_pending_reg;
        end
        UART_BAUD: rdata[15:0] = baud_shadow_reg;
        UART_CTRL: rdata[CTRL_TX_EN] = tx_en_reg;
        default:   rdata = '0;
      endcase
    end
  end

  // Bits intentionally not consumed by this block.
  logic unused_bits;
  assign unused_bits = ^{wdata[31:16], addr[1:0], q_count};

endmodule

// File: tb/tb_uart_bus_ctrl.sv
module tb_uart_bus_ctrl;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_BAUD = 4'h8;
  localparam logic [3:0] A_CTRL = 4'hC;
  localparam int         DEPTH  = 4;
  localparam logic [31:0] CPB_RESET = 32'd434;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel, we, re;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata, uart_rdata;
  logic        tx_busy, tx_start, read_rx;
  logic [7:0]  tx_data;
  logic [15:0] clk_per_bit;

  always #5 clk = ~clk;

  uart_bus_ctrl #(.TXQ_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .we          (we),
    .re          (re),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .uart_rdata  (uart_rdata),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .read_rx     (read_rx),
    .clk_per_bit (clk_per_bit)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input bit busy, input bit full, input bit empty,
                                               input bit rxe, input bit ovf, input bit pend);
    return {26'd0, pend, ovf, rxe, empty, full, busy};
  endfunction

  // ---------------------------------------------------------------------------
  // Peripheral model: raises busy the cycle after tx_start, holds it for
  // busy_len cycles; hold_busy keeps it high regardless.
  // ---------------------------------------------------------------------------
  logic [7:0]  sent_q[$];
  logic [7:0]  exp_q[$];
  int          busy_len  = 10;
  bit          hold_busy = 1'b0;
  int          busy_left = 0;
  int          cyc       = 0;
  int          last_start = -100;
  logic        prev_start = 1'b0;
  logic [15:0] frame_cpb  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_left  = 0;
        prev_start = 1'b0;
        last_start = -100;
      end else begin
        if (tx_start) begin
          check("start_pulse_one_cycle", {31'd0, prev_start}, 32'd0);
          check("start_while_busy", {31'd0, tx_busy}, 32'd0);
          check("start_gap_ge3", {31'd0, (cyc - last_start) >= 3}, 32'd1);
          sent_q.push_back(tx_data);
          frame_cpb  = clk_per_bit;
          last_start = cyc;
          busy_left  = busy_len;
        end else if (busy_left > 0) begin
          check("cpb_stable_in_frame", {16'd0, clk_per_bit}, {16'd0, frame_cpb});
        end
        prev_start = tx_start;
        if (busy_left > 0) busy_left--;
      end
      tx_busy = hold_busy || (busy_left > 0);
    end
  end

  // ---------------------------------------------------------------------------
  // CPU bus tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output logic rx);
    @(negedge clk);
    sel = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    #1;
    d  = rdata;
    rx = read_rx;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    cpu_write(A_DATA, {24'd0, b});
  endtask

  task automatic wait_busy(input logic level, input string tag);
    int n = 0;
    while (tx_busy !== level && n < 200) begin
      tick();
      n++;
    end
    check(tag, {31'd0, tx_busy}, {31'd0, level});
  endtask

  // Wait for the model's expected bytes to appear, then compare in order.
  task automatic drain_compare(input string tag);
    int budget = 0;
    logic [31:0] d;
    logic rx;
    while (sent_q.size() < exp_q.size() && budget < 2000) begin
      tick();
      budget++;
    end
    repeat (40) tick();
    check($sformatf("%s_count", tag), sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, sent_q[i]}, {24'd0, exp_q[i]});
    cpu_read(A_STAT, d, rx);
    check($sformatf("%s_status_empty", tag), {31'd0, d[2]}, 32'd1);
    sent_q.delete();
    exp_q.delete();
  endtask

  logic [31:0] rd;
  logic        rx;
  logic [7:0]  b;
  logic [15:0] new_cpb;
  logic [7:0]  model_q[$];
  bit          model_ovf;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; sel = 1'b0; we = 1'b0; re = 1'b0;
    addr = '0; wdata = '0; uart_rdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    tick();

    // ---- reset state ----
    check("reset_tx_start", {31'd0, tx_start}, 32'd0);
    check("reset_cpb", {16'd0, clk_per_bit}, CPB_RESET);
    cpu_read(A_STAT, rd, rx);
    check("reset_status", rd, status_word(0, 0, 1, 0, 0, 0));
    cpu_read(A_BAUD, rd, rx);
    check("reset_baud", rd, CPB_RESET);
    cpu_read(A_CTRL, rd, rx);
    check("reset_ctrl", rd, 32'd1);

    // ---- two bytes, in order ----
    push_byte(8'h41); exp_q.push_back(8'h41);
    push_byte(8'h42); exp_q.push_back(8'h42);
    drain_compare("basic");

    // ---- random bursts that fit the queue ----
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        push_byte(b);
        exp_q.push_back(b);
      end
      drain_compare($sformatf("burst%0d", r));
    end

    // ---- overflow with transmitter held busy ----
    hold_busy = 1'b1;
    tick(); tick();
    model_q.delete();
    model_ovf = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      b = 8'($urandom);
      push_byte(b);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else model_ovf = 1'b1;
    end
    cpu_read(A_STAT, rd, rx);
    check("ovf_status", rd, status_word(1, model_q.size() == DEPTH, model_q.size() == 0, 0, model_ovf, 0));
    cpu_write(A_STAT, 32'h10);
    cpu_read(A_STAT, rd, rx);
    check("ovf_cleared", rd, status_word(1, 1, 0, 0, 0, 0));
    hold_busy = 1'b0;
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    drain_compare("ovf_drain");

    // ---- baud change during a frame ----
    busy_len = 30;
    b = 8'($urandom);
    push_byte(b); exp_q.push_back(b);
    wait_busy(1'b1, "baud_frame_busy");
    cpu_write(A_BAUD, 32'd217);
    cpu_read(A_STAT, rd, rx);
    check("baud_pending_set", rd, status_word(1, 0, 1, 0, 0, 1));
    check("baud_cpb_held", {16'd0, clk_per_bit}, CPB_RESET);
    begin
      int n = 0;
      while (tx_busy && n < 200) begin
        check("baud_cpb_held_busy", {16'd0, clk_per_bit}, CPB_RESET);
        tick();
        n++;
      end
      n = 0;
      while (clk_per_bit != 16'd217 && n < 6) begin
        tick();
        n++;
      end
      check("baud_applied", {16'd0, clk_per_bit}, 32'd217);
      check("baud_apply_latency", {31'd0, n >= 1 && n <= 2}, 32'd1);
    end
    cpu_write(A_BAUD, 32'd2);
    cpu_read(A_BAUD, rd, rx);
    check("baud_small_ignored", rd, 32'd217);
    cpu_read(A_STAT, rd, rx);
    check("baud_pending_clear", rd, status_word(0, 0, 1, 0, 0, 0));
    busy_len = 10;
    drain_compare("baud_frame");
    for (int r = 0; r < 3; r++) begin
      new_cpb = 16'($urandom_range(4, 2000));
      cpu_write(A_BAUD, {16'hA5A5, new_cpb});
      cpu_write(A_BAUD, 32'($urandom_range(0, 3)));
      cpu_read(A_BAUD, rd, rx);
      check($sformatf("baud_rand%0d_shadow", r), rd, {16'd0, new_cpb});
      repeat (3) tick();
      check($sformatf("baud_rand%0d_active", r), {16'd0, clk_per_bit}, {16'd0, new_cpb});
    end
    b = 8'($urandom);
    push_byte(b); exp_q.push_back(b);
    drain_compare("baud_rand_frame");

    // ---- RX reads ----
    for (int r = 0; r < 4; r++) begin
      uart_rdata = (r == 0) ? 32'h0000_005A : ($urandom & 32'h7FFF_FFFF);
      cpu_read(A_DATA, rd, rx);
      check($sformatf("rx%0d_data", r), rd, uart_rdata);
      check($sformatf("rx%0d_pop", r), {31'd0, rx}, 32'd1);
      check($sformatf("rx%0d_pop_done", r), {31'd0, read_rx}, 32'd0);
    end
    uart_rdata = 32'hFFFF_FFFF;
    cpu_read(A_STAT, rd, rx);
    check("rx_empty_status", rd, status_word(0, 0, 1, 1, 0, 0));
    check("stat_read_no_pop", {31'd0, rx}, 32'd0);
    cpu_read(A_BAUD, rd, rx);
    check("baud_read_no_pop", {31'd0, rx}, 32'd0);
    uart_rdata = 32'd0;

    // ---- tx_en=0 plus flush during an in-flight frame ----
    busy_len = 30;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      push_byte(b);
      if (k == 0) exp_q.push_back(b);
    end
    wait_busy(1'b1, "flush_frame_busy");
    cpu_write(A_CTRL, 32'd0);
    cpu_read(A_STAT, rd, rx);
    check("flush_pre_status", rd, status_word(1, 0, 0, 0, 0, 0));
    cpu_write(A_CTRL, 32'd2);
    cpu_read(A_CTRL, rd, rx);
    check("flush_ctrl_readback", rd, 32'd0);
    cpu_read(A_STAT, rd, rx);
    check("flush_post_status", rd, status_word(1, 0, 1, 0, 0, 0));
    drain_compare("flush");
    busy_len = 10;

    // ---- tx_en=0 retains the queue ----
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom);
      push_byte(b);
      exp_q.push_back(b);
    end
    repeat (30) tick();
    check("txen_off_no_start", sent_q.size(), 32'd0);
    cpu_read(A_STAT, rd, rx);
    check("txen_off_retained", rd, status_word(0, 0, 0, 0, 0, 0));
    cpu_write(A_CTRL, 32'd1);
    drain_compare("txen_on");

    // ---- reset mid-frame ----
    for (int k = 0; k < 3; k++) push_byte(8'($urandom));
    wait_busy(1'b1, "rst_frame_busy");
    sent_q.delete();
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_cpb", {16'd0, clk_per_bit}, CPB_RESET);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    cpu_read(A_STAT, rd, rx);
    check("rst_status", rd, status_word(0, 0, 1, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    repeat (40) tick();
    check("rst_no_tx_after", sent_q.size(), 32'd0);
    cpu_read(A_BAUD, rd, rx);
    check("rst_baud", rd, CPB_RESET);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_ctrl.md
Name: uart_bus_ctrl

Overview:
- Memory-mapped controller between the CPU load/store path and uart_peripheral.
- Buffers CPU TX writes in a small queue and schedules each byte onto the peripheral's tx_start/tx_data handshake when the transmitter is idle.
- Turns CPU reads into single-cycle read_rx pops.
- Owns the clk_per_bit baud configuration, applying new values only between frames.

Parameters:
TXQ_DEPTH, 4, TX queue entries (power of 2, >=2)
DEFAULT_CPB, 16'd434, clk_per_bit after reset (50 MHz / 115200)
MIN_CPB, 16'd4, smallest accepted baud value

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sel  in  1  CPU access targets this block
we  in  1  CPU store strobe (qualified by sel)
re  in  1  CPU load strobe (qualified by sel)
addr  in  4  byte offset; addr[3:2] selects register
wdata  in  32  store data
rdata  out  32  load data (combinational)
uart_rdata  in  32  peripheral output_data (0xFFFFFFFF = RX empty)
tx_busy  in  1  peripheral transmitter busy
tx_start  out  1  one-cycle launch pulse to peripheral
tx_data  out  8  byte presented with tx_start
read_rx  out  1  one-cycle RX FIFO pop
clk_per_bit  out  16  active baud divisor to peripheral

Behaviour:
- Register map:
  - 0x0 DATA: a write pushes wdata[7:0] to the TX queue. A read returns uart_rdata and asserts read_rx in the same cycle.
  - 0x4 STATUS (RO except bit4):
    - bit0 tx_busy
    - bit1 txq_full
    - bit2 txq_empty
    - bit3 rx_empty (uart_rdata==32'hFFFFFFFF)
    - bit4 tx_overflow, sticky; writing 1 clears it
    - bit5 baud_pending
  - 0x8 BAUD: R/W shadow divisor. Writes with wdata[15:0] < MIN_CPB are ignored. Reads return the shadow value.
  - 0xC CTRL:
    - bit0 tx_en (reset 1), R/W
    - bit1 flush: write-1, self-clearing, reads 0
- Unmapped or unselected reads: rdata=0. read_rx is high only for sel&re&addr[3:2]==0; it is never asserted for writes or other offsets.
- Reset (reset low, async):
  - queue empty; tx_overflow=0
  - tx_start=0, tx_data=0
  - clk_per_bit and shadow = DEFAULT_CPB; baud_pending=0
  - FSM=IDLE
- TX queue: circular, TXQ_DEPTH entries, with pointers plus a count.
  - Push when full: data dropped, tx_overflow set.
  - Push and scheduler pop in the same cycle while full: both succeed; the count is unchanged.
  - Pointers wrap modulo TXQ_DEPTH.
- Scheduler FSM (registered):
  - IDLE:
    - If baud_pending & !tx_busy: load clk_per_bit from shadow, clear baud_pending, and stay in IDLE that cycle.
    - Otherwise, if tx_en & !empty & !tx_busy: tx_data<=head, tx_start<=1 for exactly one cycle, pop, go to LAUNCH.
  - LAUNCH: wait for tx_busy=1, then go to ACTIVE. If tx_busy is not seen within 2 cycles, go to ACTIVE anyway (deadlock guard).
  - ACTIVE: wait for tx_busy=0, then go to IDLE.
  - Minimum gap between consecutive tx_start pulses is 3 cycles. tx_data holds its value until the next launch.
- Baud write: updates the shadow and sets baud_pending. The new value must never change mid-frame.
- flush: empties the queue in the cycle of the write. An in-flight frame (LAUNCH/ACTIVE) completes normally. A push in the same cycle as flush is discarded.
- tx_en=0: no new launches. The current frame completes and the queue contents are retained.
- Reset mid-frame: the FSM returns to IDLE immediately and the queue is cleared. The peripheral is reset by the same signal.

Decomposition:
- Shared package uart_pkg holds:
  - register offsets (UART_DATA=2'd0, UART_STAT=2'd1, UART_BAUD=2'd2, UART_CTRL=2'd3)
  - STATUS/CTRL bit indices
  - FSM state encoding (IDLE/LAUNCH/ACTIVE)
  - DEFAULT_CPB
- One natural sub-module: uart_txq (parameterised circular FIFO with push/pop/flush/full/empty/count).

Test Plan:
- Reset then read STATUS → 0x04 (txq_empty); read BAUD → 434; clk_per_bit=434; tx_start=0.
- Write DATA 0x41, 0x42 with tx_busy modelled 10 cycles after each tx_start:
  - one-cycle tx_start with tx_data=0x41, then 0x42 only after tx_busy falls
  - queue empty afterwards
- Hold tx_busy=1 and push 5 bytes into a 4-deep queue:
  - txq_full=1, tx_overflow=1, 5th byte never transmitted
  - writing 0x10 to STATUS clears bit4
- Write BAUD=217 during ACTIVE:
  - clk_per_bit stays 434 until tx_busy falls, then 217 one cycle later
  - baud_pending=1 during the wait
  - BAUD=2 is ignored
- With uart_rdata=0x0000005A, read DATA:
  - rdata=0x5A, read_rx high exactly one cycle
  - with uart_rdata=0xFFFFFFFF, STATUS bit3=1
  - STATUS read never asserts read_rx
- Queue 3 bytes, set tx_en=0, write flush during an in-flight frame:
  - in-flight frame completes
  - no further tx_start
  - STATUS shows empty
